// File: rtl/execute_mc.sv
// execute_mc: multi-cycle execute stage for ALU, branch and memory requests.
// Divide and remainder run on an iterative restoring divider.

package execute_mc_pkg;
    typedef enum logic [4:0] {
        ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, PASS,
        MUL, MULH, MULHU, DIV, DIVU, REM, REMU, ANONE
    } alu_op_e;

    typedef enum logic [3:0] {
        BNONE, BEQ, BNE, BLT, BGE, BLTU, BGEU, JAL, JALR
    } br_op_e;

    typedef enum logic [1:0] {
        MNONE, LOAD, STORE
    } mem_op_e;
endpackage

module execute_mc
    import execute_mc_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int DIV_UNROLL = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  alu_op_e           in_alu_op,
    input  br_op_e            in_br_op,
    input  mem_op_e           in_mem_op,
    input  logic [2:0]        in_funct3,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_rs1_val,
    input  logic [XLEN-1:0]   in_rs2_val,
    input  logic [XLEN-1:0]   in_imm,
    input  logic              in_use_imm,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_result,
    output logic              out_branch_taken,
    output logic [XLEN-1:0]   out_branch_target,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic [XLEN-1:0]   out_mem_addr,
    output logic [XLEN-1:0]   out_mem_data,
    output logic [XLEN/8-1:0] out_mem_mask,
    output logic              busy
);

    localparam int SHW   = $clog2(XLEN);
    localparam int MW    = XLEN / 8;
    localparam int STEPS = XLEN / DIV_UNROLL;
    localparam int CW    = $clog2(STEPS + 1);
    localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_e;

    state_e            state;
    logic [XLEN-1:0]   a, b;
    logic [SHW-1:0]    shamt;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   mulh;
    logic              is_div, div_signed, div_rem;
    logic              div_zero, div_ovf, div_special;
    logic [XLEN-1:0]   div_fast, alu_res, res_single;
    logic              br_taken, is_link;
    logic [XLEN-1:0]   br_target;
    logic              mem_rd, mem_wr;
    logic [MW-1:0]     mem_mask;
    logic              accept, start_div, out_free;
    logic [XLEN-1:0]   q, d, r, q_n, r_n, div_res;
    logic [XLEN:0]     rr;
    logic [CW-1:0]     cnt;
    logic              prep, sgn, neg_q, neg_r, want_rem;

    assign a     = in_rs1_val;
    assign b     = (in_use_imm || in_mem_op != MNONE) ? in_imm : in_rs2_val;
    assign shamt = b[SHW-1:0];

    // One unsigned multiplier; signed high half is corrected from it.
    assign prod = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
    assign mulh = prod[2*XLEN-1:XLEN]
                - (a[XLEN-1] ? b : '0)
                - (b[XLEN-1] ? a : '0);

    assign is_div      = in_alu_op inside {DIV, DIVU, REM, REMU};
    assign div_signed  = in_alu_op inside {DIV, REM};
    assign div_rem     = in_alu_op inside {REM, REMU};
    assign div_zero    = (b == '0);
    assign div_ovf     = div_signed && (a == MIN) && (b == '1);
    assign div_special = div_zero || div_ovf;

    always_comb begin
        div_fast = '0;
        if (div_zero)
            div_fast = div_rem ? a : '1;
        else if (div_ovf)
            div_fast = div_rem ? '0 : a;
    end

    always_comb begin
        alu_res = '0;
        unique case (in_alu_op)
            ADD:   alu_res = a + b;
            SUB:   alu_res = a - b;
            AND:   alu_res = a & b;
            OR:    alu_res = a | b;
            XOR:   alu_res = a ^ b;
            SLL:   alu_res = a << shamt;
            SRL:   alu_res = a >> shamt;
            SRA:   alu_res = $unsigned($signed(a) >>> shamt);
            SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            SLTU:  alu_res = {{(XLEN-1){1'b0}}, a < b};
            PASS:  alu_res = b;
            MUL:   alu_res = prod[XLEN-1:0];
            MULH:  alu_res = mulh;
            MULHU: alu_res = prod[2*XLEN-1:XLEN];
            DIV, DIVU, REM, REMU: alu_res = div_fast;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        br_taken  = 1'b0;
        is_link   = 1'b0;
        br_target = in_pc + in_imm;
        unique case (in_br_op)
            BEQ:  br_taken = (in_rs1_val == in_rs2_val);
            BNE:  br_taken = (in_rs1_val != in_rs2_val);
            BLT:  br_taken = $signed(in_rs1_val) < $signed(in_rs2_val);
            BGE:  br_taken = $signed(in_rs1_val) >= $signed(in_rs2_val);
            BLTU: br_taken = in_rs1_val < in_rs2_val;
            BGEU: br_taken = in_rs1_val >= in_rs2_val;
            JAL: begin
                br_taken = 1'b1;
                is_link  = 1'b1;
            end
            JALR: begin
                br_taken  = 1'b1;
                is_link   = 1'b1;
                br_target = (in_rs1_val + in_imm) & ~XLEN'(1);
            end
            default: br_target = '0;
        endcase
    end

    assign res_single = is_link ? in_pc + XLEN'(4) : alu_res;

    always_comb begin
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        mem_mask = '0;
        if (in_mem_op == LOAD) begin
            unique case (in_funct3)
                3'd0, 3'd1, 3'd2, 3'd4, 3'd5: mem_rd = 1'b1;
                3'd3, 3'd6: mem_rd = (XLEN == 64);
                default: mem_rd = 1'b0;
            endcase
        end else if (in_mem_op == STORE) begin
            unique case (in_funct3)
                3'd0: {mem_wr, mem_mask} = {1'b1, MW'(1)};
                3'd1: {mem_wr, mem_mask} = {1'b1, MW'(3)};
                3'd2: {mem_wr, mem_mask} = {1'b1, MW'(15)};
                3'd3: if (XLEN == 64) {mem_wr, mem_mask} = {1'b1, MW'(255)};
                default: mem_wr = 1'b0;
            endcase
        end
    end

    // DIV_UNROLL restoring steps per cycle on magnitudes.
    always_comb begin
        q_n = q;
        r_n = r;
        rr  = '0;
        for (int i = 0; i < DIV_UNROLL; i++) begin
            rr  = {r_n, q_n[XLEN-1]};
            q_n = q_n << 1;
            if (rr >= {1'b0, d}) begin
                rr     = rr - {1'b0, d};
                q_n[0] = 1'b1;
            end
            r_n = rr[XLEN-1:0];
        end
    end

    assign div_res = want_rem ? (neg_r ? -r : r) : (neg_q ? -q : q);

    assign out_free  = !out_valid || out_ready;
    assign in_ready  = (state == S_IDLE) && out_free && reset;
    assign accept    = in_valid && in_ready && !flush;
    assign start_div = accept && is_div && !div_special;
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state             <= S_IDLE;
            prep              <= 1'b0;
            sgn               <= 1'b0;
            neg_q             <= 1'b0;
            neg_r             <= 1'b0;
            want_rem          <= 1'b0;
            cnt               <= '0;
            q                 <= '0;
            d                 <= '0;
            r                 <= '0;
            out_valid         <= 1'b0;
            out_result        <= '0;
            out_branch_taken  <= 1'b0;
            out_branch_target <= '0;
            out_mem_read      <= 1'b0;
            out_mem_write     <= 1'b0;
            out_mem_addr      <= '0;
            out_mem_data      <= '0;
            out_mem_mask      <= '0;
        end else if (flush) begin
            state     <= S_IDLE;
            prep      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (out_ready)
                out_valid <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start_div) begin
                        state    <= S_DIV;
                        prep     <= 1'b1;
                        q        <= a;
                        d        <= b;
                        r        <= '0;
                        sgn      <= div_signed;
                        neg_q    <= div_signed && (a[XLEN-1] ^ b[XLEN-1]);
                        neg_r    <= div_signed && a[XLEN-1];
                        want_rem <= div_rem;
                    end else if (accept) begin
                        out_valid         <= 1'b1;
                        out_result        <= res_single;
                        out_branch_taken  <= br_taken;
                        out_branch_target <= br_target;
                        out_mem_read      <= mem_rd;
                        out_mem_write     <= mem_wr;
                        out_mem_addr      <= in_rs1_val + in_imm;
                        out_mem_data      <= in_rs2_val;
                        out_mem_mask      <= mem_mask;
                    end
                end
                S_DIV: begin
                    if (prep) begin
                        prep <= 1'b0;
                        cnt  <= CW'(STEPS);
                        if (sgn && q[XLEN-1]) q <= -q;
                        if (sgn && d[XLEN-1]) d <= -d;
                    end else begin
                        q   <= q_n;
                        r   <= r_n;
                        cnt <= cnt - CW'(1);
                        if (cnt == CW'(1)) state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_free) begin
                        state             <= S_IDLE;
                        out_valid         <= 1'b1;
                        out_result        <= div_res;
                        out_branch_taken  <= 1'b0;
                        out_branch_target <= '0;
                        out_mem_read      <= 1'b0;
                        out_mem_write     <= 1'b0;
                        out_mem_addr      <= '0;
                        out_mem_data      <= '0;
                        out_mem_mask      <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_execute_mc.sv
// Directed-vector bench for execute_mc (XLEN=32, DIV_UNROLL=1).
// Table of single-cycle vectors plus hand sequences for divide/flush/reset.

module tb_execute_mc;
    import execute_mc_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    alu_op_e     in_alu_op;
    br_op_e      in_br_op;
    mem_op_e     in_mem_op;
    logic [2:0]  in_funct3;
    logic [31:0] in_pc, in_rs1_val, in_rs2_val, in_imm;
    logic        in_use_imm, flush;
    logic        out_valid, out_ready;
    logic [31:0] out_result, out_branch_target;
    logic        out_branch_taken, out_mem_read, out_mem_write;
    logic [31:0] out_mem_addr, out_mem_data;
    logic [3:0]  out_mem_mask;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc;
    logic [31:0] ea;

    typedef struct {
        alu_op_e     alu;
        br_op_e      br;
        mem_op_e     mem;
        logic [2:0]  f3;
        logic [31:0] pc, rs1, rs2, imm;
        logic        ui;
        logic [31:0] res;
        logic        tk;
        logic [31:0] tgt;
        logic        rd, wr;
        logic [3:0]  mask;
    } vec_t;

    vec_t vt[$];

    execute_mc #(.XLEN(32), .DIV_UNROLL(1)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_op(in_alu_op), .in_br_op(in_br_op),
        .in_mem_op(in_mem_op), .in_funct3(in_funct3),
        .in_pc(in_pc), .in_rs1_val(in_rs1_val),
        .in_rs2_val(in_rs2_val), .in_imm(in_imm),
        .in_use_imm(in_use_imm), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result),
        .out_branch_taken(out_branch_taken),
        .out_branch_target(out_branch_target),
        .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .out_mem_addr(out_mem_addr), .out_mem_data(out_mem_data),
        .out_mem_mask(out_mem_mask), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic put(input alu_op_e op, input br_op_e br,
                       input mem_op_e mem, input logic [2:0] f3,
                       input logic [31:0] pc, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] imm,
                       input logic ui);
        in_valid   = 1'b1;
        in_alu_op  = op;
        in_br_op   = br;
        in_mem_op  = mem;
        in_funct3  = f3;
        in_pc      = pc;
        in_rs1_val = rs1;
        in_rs2_val = rs2;
        in_imm     = imm;
        in_use_imm = ui;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            tick();
            cyc++;
        end
    endtask

    task automatic run_div(input string nm, input alu_op_e op,
                           input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] exp);
        put(op, BNONE, MNONE, 3'd0, 32'h0, x, y, 32'h0, 1'b0);
        tick();
        in_valid = 1'b0;
        chk({nm, " busy"}, 32'(busy), 32'd1);
        chk({nm, " in_ready"}, 32'(in_ready), 32'd0);
        wait_valid();
        chk({nm, " latency"}, cyc, 32'd34);
        chk({nm, " result"}, out_result, exp);
        chk({nm, " busy_end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        vt.push_back('{ADD, BNONE, MNONE, 3'd0, 32'h0, 32'd5, 32'd7, 32'h0, 1'b0,
                       32'd12, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0});
        vt.push_back('{SUB, BNONE, MNONE, 3'd0, 32'h0, 32'd3, 32'd5, 32'h0, 1'b0,
                       32'hFFFFFFFE, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0});
        vt.push_back('{AND, BNONE, MNONE, 3'd0, 32'h0, 32'hF0F0, 32'hFFFF, 32'h0FF0, 1'b1,
                       32'h00F0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0});
        vt.push_back('{OR, BNONE, MNONE, 3'd0, 32'h0, 32'hF000, 32'h000F, 32'h0, 1'b0,
                       32'hF00F, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0});
        vt.push_back('{XOR, BNONE, MNONE, 3'd0, 32'h0, 32'hFF00, 32'h0FF0, 32'h0, 1'b0,
                       32'hF0F0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0});
        vt.push_back('{SLL, BNONE, MNONE, 3'd0, 32'h0, 32'd1, 32'd33, 32'h0, 1'b0,
                       32'd2, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0});
        vt.push_back('{SRL, BNONE, MNONE, 3'd0, 32'h0, 32'h80000000, 32'd31, 32'h0, 1'b0,
                       32'd1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0});
        vt.push_back('{SRA, BNONE, MNONE, 3'd0, 32'h0, 32'h80000000, 32'd0, 32'd4, 1'b1,
                       32'hF8000000, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0});
        vt.push_back('{SLT, BNONE, MNONE, 3'd0, 32'h0, 32'hFFFFFFFF, 32'd1, 32'h0, 1'b0,
                       32'd1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0});
        vt.push_back('{SLTU, BNONE, MNONE, 3'd0, 32'h0, 32'hFFFFFFFF, 32'd1, 32'h0, 1'b0,
                       32'd0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0});
        vt.push_back('{PASS, BNONE, MNONE, 3'd0, 32'h0, 32'h0, 32'h0, 32'h1234, 1'b1,
                       32'h1234, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0});
        vt.push_back('{MUL, BNONE, MNONE, 3'd0, 32'h0, 32'hFFFFFFFF, 32'd3, 32'h0, 1'b0,
                       32'hFFFFFFFD, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0});
        vt.push_back('{MULH, BNONE, MNONE, 3'd0, 32'h0, 32'hFFFFFFFF, 32'd3, 32'h0, 1'b0,
                       32'hFFFFFFFF, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0});
        vt.push_back('{MULHU, BNONE, MNONE, 3'd0, 32'h0, 32'hFFFFFFFF, 32'd3, 32'h0, 1'b0,
                       32'd2, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0});
        vt.push_back('{MULH, BNONE, MNONE, 3'd0, 32'h0, 32'h80000000, 32'h80000000, 32'h0, 1'b0,
                       32'h40000000, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0});
        vt.push_back('{MULH, BNONE, MNONE, 3'd0, 32'h0, 32'h80000000, 32'h7FFFFFFF, 32'h0, 1'b0,
                       32'hC0000000, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0});
        vt.push_back('{DIVU, BNONE, MNONE, 3'd0, 32'h0, 32'd123, 32'd0, 32'h0, 1'b0,
                       32'hFFFFFFFF, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0});
        vt.push_back('{REMU, BNONE, MNONE, 3'd0, 32'h0, 32'd123, 32'd0, 32'h0, 1'b0,
                       32'd123, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0});
        vt.push_back('{REM, BNONE, MNONE, 3'd0, 32'h0, 32'hFFFFFFFB, 32'd0, 32'h0, 1'b0,
                       32'hFFFFFFFB, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0});
        vt.push_back('{DIV, BNONE, MNONE, 3'd0, 32'h0, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1'b0,
                       32'h80000000, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0});
        vt.push_back('{REM, BNONE, MNONE, 3'd0, 32'h0, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1'b0,
                       32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0});
        vt.push_back('{SUB, BEQ, MNONE, 3'd0, 32'h100, 32'd9, 32'd9, 32'h20, 1'b0,
                       32'h0, 1'b1, 32'h120, 1'b0, 1'b0, 4'h0});
        vt.push_back('{SUB, BNE, MNONE, 3'd0, 32'h100, 32'd9, 32'd9, 32'h20, 1'b0,
                       32'h0, 1'b0, 32'h120, 1'b0, 1'b0, 4'h0});
        vt.push_back('{SUB, BLT, MNONE, 3'd0, 32'h100, 32'hFFFFFFFF, 32'd1, 32'h20, 1'b0,
                       32'hFFFFFFFE, 1'b1, 32'h120, 1'b0, 1'b0, 4'h0});
        vt.push_back('{SUB, BGE, MNONE, 3'd0, 32'h100, 32'hFFFFFFFF, 32'd1, 32'h20, 1'b0,
                       32'hFFFFFFFE, 1'b0, 32'h120, 1'b0, 1'b0, 4'h0});
        vt.push_back('{SUB, BLTU, MNONE, 3'd0, 32'h100, 32'hFFFFFFFF, 32'd1, 32'h20, 1'b0,
                       32'hFFFFFFFE, 1'b0, 32'h120, 1'b0, 1'b0, 4'h0});
        vt.push_back('{SUB, BGEU, MNONE, 3'd0, 32'h100, 32'hFFFFFFFF, 32'd1, 32'h20, 1'b0,
                       32'hFFFFFFFE, 1'b1, 32'h120, 1'b0, 1'b0, 4'h0});
        vt.push_back('{SUB, BGE, MNONE, 3'd0, 32'h100, 32'd5, 32'd5, 32'h20, 1'b0,
                       32'h0, 1'b1, 32'h120, 1'b0, 1'b0, 4'h0});
        vt.push_back('{ADD, JAL, MNONE, 3'd0, 32'h200, 32'h0, 32'h0, 32'hFFFFFFF0, 1'b0,
                       32'h204, 1'b1, 32'h1F0, 1'b0, 1'b0, 4'h0});
        vt.push_back('{ADD, JALR, MNONE, 3'd0, 32'h40, 32'h201, 32'h0, 32'd2, 1'b1,
                       32'h44, 1'b1, 32'h202, 1'b0, 1'b0, 4'h0});
        vt.push_back('{ADD, BNONE, LOAD, 3'd2, 32'h0, 32'h1000, 32'h0, 32'd8, 1'b0,
                       32'h1008, 1'b0, 32'h0, 1'b1, 1'b0, 4'h0});
        vt.push_back('{ADD, BNONE, LOAD, 3'd4, 32'h0, 32'h1000, 32'h0, 32'd8, 1'b0,
                       32'h1008, 1'b0, 32'h0, 1'b1, 1'b0, 4'h0});
        vt.push_back('{ADD, BNONE, LOAD, 3'd3, 32'h0, 32'h1000, 32'h0, 32'd8, 1'b0,
                       32'h1008, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0});
        vt.push_back('{ADD, BNONE, LOAD, 3'd6, 32'h0, 32'h1000, 32'h0, 32'd8, 1'b0,
                       32'h1008, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0});
        vt.push_back('{ADD, BNONE, LOAD, 3'd7, 32'h0, 32'h1000, 32'h0, 32'd8, 1'b0,
                       32'h1008, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0});
        vt.push_back('{ADD, BNONE, STORE, 3'd0, 32'h0, 32'h100, 32'hABCD, 32'd4, 1'b0,
                       32'h104, 1'b0, 32'h0, 1'b0, 1'b1, 4'h1});
        vt.push_back('{ADD, BNONE, STORE, 3'd1, 32'h0, 32'h100, 32'hABCD, 32'd4, 1'b0,
                       32'h104, 1'b0, 32'h0, 1'b0, 1'b1, 4'h3});
        vt.push_back('{ADD, BNONE, STORE, 3'd2, 32'h0, 32'h100, 32'hABCD, 32'd4, 1'b0,
                       32'h104, 1'b0, 32'h0, 1'b0, 1'b1, 4'hF});
        vt.push_back('{ADD, BNONE, STORE, 3'd3, 32'h0, 32'h100, 32'hABCD, 32'd4, 1'b0,
                       32'h104, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0});
        vt.push_back('{ADD, BNONE, STORE, 3'd5, 32'h0, 32'h100, 32'hABCD, 32'd4, 1'b0,
                       32'h104, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0});

        reset     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        put(ANONE, BNONE, MNONE, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        in_valid = 1'b0;
        tick();
        tick();
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst result", out_result, 32'h0);
        chk("rst target", out_branch_target, 32'h0);
        chk("rst taken", 32'(out_branch_taken), 32'd0);
        chk("rst addr", out_mem_addr, 32'h0);
        chk("rst mask", 32'(out_mem_mask), 32'd0);
        chk("rst write", 32'(out_mem_write), 32'd0);
        reset = 1'b1;
        tick();
        chk("post-rst in_ready", 32'(in_ready), 32'd1);

        // back-to-back single-cycle ops
        put(ADD, BNONE, MNONE, 3'd0, 32'h0, 32'd5, 32'd7, 32'h0, 1'b0);
        tick();
        chk("b2b add valid", 32'(out_valid), 32'd1);
        chk("b2b add result", out_result, 32'd12);
        chk("b2b in_ready", 32'(in_ready), 32'd1);
        put(SRA, BNONE, MNONE, 3'd0, 32'h0, 32'h80000000, 32'h0, 32'd4, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("b2b sra valid", 32'(out_valid), 32'd1);
        chk("b2b sra result", out_result, 32'hF8000000);
        tick();
        chk("b2b drained", 32'(out_valid), 32'd0);

        foreach (vt[i]) begin
            put(vt[i].alu, vt[i].br, vt[i].mem, vt[i].f3, vt[i].pc,
                vt[i].rs1, vt[i].rs2, vt[i].imm, vt[i].ui);
            tick();
            ea = vt[i].rs1 + vt[i].imm;
            chk($sformatf("v%0d valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("v%0d result", i), out_result, vt[i].res);
            chk($sformatf("v%0d taken", i), 32'(out_branch_taken), 32'(vt[i].tk));
            chk($sformatf("v%0d target", i), out_branch_target, vt[i].tgt);
            chk($sformatf("v%0d read", i), 32'(out_mem_read), 32'(vt[i].rd));
            chk($sformatf("v%0d write", i), 32'(out_mem_write), 32'(vt[i].wr));
            chk($sformatf("v%0d addr", i), out_mem_addr, ea);
            chk($sformatf("v%0d data", i), out_mem_data, vt[i].rs2);
            if (vt[i].mem != LOAD)
                chk($sformatf("v%0d mask", i), 32'(out_mem_mask), 32'(vt[i].mask));
        end
        in_valid = 1'b0;
        tick();

        run_div("div -7/2", DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
        run_div("rem -7/2", REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
        run_div("divu 100/7", DIVU, 32'd100, 32'd7, 32'd14);
        run_div("remu 100/7", REMU, 32'd100, 32'd7, 32'd2);
        run_div("div 7/-2", DIV, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD);
        run_div("rem 7/-2", REM, 32'd7, 32'hFFFFFFFE, 32'd1);

        // divide result lands while consumer stalls
        put(DIVU, BNONE, MNONE, 3'd0, 32'h0, 32'd100, 32'd7, 32'h0, 1'b0);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        wait_valid();
        chk("divbp latency", cyc, 32'd34);
        chk("divbp result", out_result, 32'd14);
        tick();
        chk("divbp hold valid", 32'(out_valid), 32'd1);
        chk("divbp hold result", out_result, 32'd14);
        out_ready = 1'b1;
        tick();
        chk("divbp drained", 32'(out_valid), 32'd0);

        // store held under backpressure
        out_ready = 1'b0;
        put(ADD, BNONE, STORE, 3'd1, 32'h0, 32'h100, 32'hABCD, 32'd4, 1'b0);
        tick();
        in_valid = 1'b0;
        repeat (3) begin
            chk("st valid", 32'(out_valid), 32'd1);
            chk("st addr", out_mem_addr, 32'h104);
            chk("st mask", 32'(out_mem_mask), 32'h3);
            chk("st write", 32'(out_mem_write), 32'd1);
            chk("st data", out_mem_data, 32'hABCD);
            chk("st in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("st drained", 32'(out_valid), 32'd0);
        chk("st in_ready after", 32'(in_ready), 32'd1);

        // flush beats a same-cycle accept
        put(ADD, BNONE, MNONE, 3'd0, 32'h0, 32'd5, 32'd7, 32'h0, 1'b0);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush drop", 32'(out_valid), 32'd0);

        // flush aborts a divide, then JALR
        put(DIV, BNONE, MNONE, 3'd0, 32'h0, 32'hFFFFFFF9, 32'd2, 32'h0, 1'b0);
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        chk("fl busy before", 32'(busy), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl busy after", 32'(busy), 32'd0);
        chk("fl in_ready", 32'(in_ready), 32'd1);
        chk("fl out_valid", 32'(out_valid), 32'd0);
        put(ADD, JALR, MNONE, 3'd0, 32'h40, 32'h201, 32'h0, 32'd2, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("jalr valid", 32'(out_valid), 32'd1);
        chk("jalr target", out_branch_target, 32'h202);
        chk("jalr result", out_result, 32'h44);
        chk("jalr taken", 32'(out_branch_taken), 32'd1);
        repeat (40) tick();
        chk("fl no stale", 32'(out_valid), 32'd0);

        // reset mid-divide
        put(DIVU, BNONE, MNONE, 3'd0, 32'h0, 32'd100, 32'd7, 32'h0, 1'b0);
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        reset = 1'b0;
        tick();
        chk("mr busy", 32'(busy), 32'd0);
        chk("mr in_ready", 32'(in_ready), 32'd0);
        chk("mr out_valid", 32'(out_valid), 32'd0);
        reset = 1'b1;
        tick();
        chk("mr in_ready after", 32'(in_ready), 32'd1);
        repeat (40) tick();
        chk("mr no stale", 32'(out_valid), 32'd0);
        run_div("divu after reset", DIVU, 32'd100, 32'd7, 32'd14);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/execute_mc.md
# execute_mc

Parametrised multi-cycle execute stage for the tribe core. It computes ALU, branch and memory-request results for one instruction at a time. Single-cycle ops pass through in one cycle; divide/remainder ops use an iterative divider. Each operand bundle enters through a valid/ready handshake on the input side. Each registered result leaves through a valid/ready handshake on the output side, which lets the stage stall on backpressure and absorb variable latency. It sits between decode/regfile read and the memory/writeback stages.

## Interface
- XLEN, 32, datapath width; 32 or 64 only
- DIV_UNROLL, 1, quotient bits retired per divider cycle; 1, 2 or 4; must divide XLEN
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-low (0 = reset); single clock domain
- in_valid  in  1  operand bundle valid
- in_ready  out  1  stage can accept a bundle this cycle
- in_alu_op  in  Alu_pkg enum  ADD,SUB,AND,OR,XOR,SLL,SRL,SRA,SLT,SLTU,PASS,MUL,MULH,MULHU,DIV,DIVU,REM,REMU,ANONE
- in_br_op  in  Br_pkg enum  BNONE,BEQ,BNE,BLT,BGE,BLTU,BGEU,JAL,JALR
- in_mem_op  in  Mem_pkg enum  MNONE,LOAD,STORE
- in_funct3  in  3  access size/sign
- in_pc, in_rs1_val, in_rs2_val, in_imm  in  XLEN each  operands; imm already sign-extended
- in_use_imm  in  1  ALU operand b = imm instead of rs2_val
- flush  in  1  kill in-flight and held work
- out_valid  out  1  result registered
- out_ready  in  1  consumer accepts result
- out_result  out  XLEN  ALU result or link address
- out_branch_taken  out  1
- out_branch_target  out  XLEN
- out_mem_read, out_mem_write  out  1 each
- out_mem_addr, out_mem_data  out  XLEN each
- out_mem_mask  out  XLEN/8  byte enables
- busy  out  1  divider FSM not IDLE

## Operation
- Accept when in_valid && in_ready. in_ready = (state==IDLE) && (!out_valid || out_ready) && reset.
- Operand a = rs1_val. b = imm when in_use_imm or mem_op!=MNONE, else rs2_val.
- Shifts use the low log2(XLEN) bits of b. SRA is arithmetic.
- MUL returns the low XLEN bits. MULH returns the high XLEN bits of signed×signed; MULHU returns them for unsigned×unsigned. Both complete in a single cycle.
- Branch compares use rs1_val vs rs2_val directly: equality, signed less-than, unsigned less-than.
- JAL: target = pc+imm, taken=1, result = pc+4.
- JALR: target = (rs1_val+imm) & ~1, taken=1, result = pc+4.
- Conditional branches: target = pc+imm.
- BNONE: taken=0, target=0.
- Memory address = rs1_val+imm; data = rs2_val.
- STORE mask by funct3: 0→0x1, 1→0x3, 2→0xF, 3→0xFF (XLEN=64 only). Any other funct3 gives out_mem_write=0 and mask=0.
- LOAD sets out_mem_read for funct3 0,1,2,4,5, plus 3 and 6 when XLEN=64. Other funct3 values give 0.
- FSM states:
  - IDLE: an accepted DIV/DIVU/REM/REMU goes to DIV, except for special cases.
  - DIV: runs XLEN/DIV_UNROLL restoring-division steps on magnitudes, then goes to DONE.
  - DONE: applies signs, loads the output register, returns to IDLE.
- Special divide cases bypass the FSM and complete as single-cycle ops:
  - Divisor 0: quotient = all ones; remainder = dividend.
  - Signed overflow (-2^(XLEN-1) / -1): quotient = dividend; remainder = 0.
- Signed remainder takes the sign of the dividend.
- Output register holds all out_* stable while out_valid && !out_ready. It clears out_valid on handshake unless a new result loads the same cycle.
- flush: clears out_valid, aborts the divider to IDLE, and drops any bundle offered that cycle (flush wins over accept). in_ready is 1 the next cycle.

## Timing
- During reset low: out_valid=0, in_ready=0, busy=0, and all out_* data/mask/flags are 0. FSM is IDLE.
- Single-cycle op accepted at edge N → out_valid at N+1.
- Divide accepted at edge N → out_valid at N+XLEN/DIV_UNROLL+2 (steps + DONE). in_ready=0 throughout.
- Back-to-back single-cycle ops with out_ready=1 sustain one result per cycle.
- Reset asserted mid-divide: the FSM returns to IDLE on that edge and partial state is discarded.
- out_ready=0 while DONE completes: the FSM waits in DONE until the output register is free.

## Test plan
- Reset low 2 cycles then high → all outputs 0, in_ready=1 the cycle after release.
- ADD rs1=5, rs2=7 with out_ready=1; then SRA rs1=0x80000000, b=4 → out_result 12 at N+1, then 0xF8000000 at N+2, no bubbles.
- DIV -7/2 (XLEN=32, DIV_UNROLL=1) → out_result 0xFFFFFFFD after 34 cycles; REM -7/2 → 0xFFFFFFFF; busy high during the divide.
- DIVU x/0 → 0xFFFFFFFF in 1 cycle. DIV 0x80000000/-1 → 0x80000000. REM 0x80000000/-1 → 0.
- STORE funct3=1, rs1=0x100, imm=4, rs2=0xABCD; hold out_ready=0 for 3 cycles → addr 0x104, mask 0x3, write=1, outputs stable, in_ready=0 until drained.
- JALR pc=0x40, rs1=0x201, imm=2 with flush pulsed mid-way through a preceding DIV → divide aborted, JALR gives target 0x202, result 0x44, taken=1.
